// File: rtl/stdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stdp_pkg
//  Purpose  : Shared defaults and FSM encoding for the STDP update scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package stdp_pkg;

    localparam int N_SYN_DEF  = 4;
    localparam int ADDR_W_DEF = 2;
    localparam int W_W_DEF    = 8;
    localparam int WINDOW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin pick among pending synapses, starting after the
//             previous grant.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import stdp_pkg::*;
#(
    parameter int N_SYN  = N_SYN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [N_SYN-1:0]  req,
    input  logic [ADDR_W-1:0] last_grant,
    output logic [ADDR_W-1:0] grant,
    output logic              valid
);

    logic [ADDR_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest request wins;
    // offset N_SYN wraps onto last_grant itself and ranks lowest.
    always_comb begin
        grant = last_grant;
        valid = 1'b0;
        w_idx = '0;
        for (int off = N_SYN; off >= 1; off--) begin
            w_idx = last_grant + ADDR_W'(off);
            if (req[w_idx]) begin
                grant = w_idx;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stdp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : stdp_sched
//  Purpose  : Tracks pre/post spike ages and serialises LTP/LTD weight
//             read-modify-write updates through a single weight port.
//  Revision : 1.0  initial release
// ============================================================================
module stdp_sched
    import stdp_pkg::*;
#(
    parameter int N_SYN    = N_SYN_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int LTP_STEP = 1,
    parameter int LTD_STEP = 1,
    parameter int WINDOW   = WINDOW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_SYN-1:0]  pre_spike,
    input  logic              post_spike,
    input  logic [W_W-1:0]    wt_rdata,
    output logic [ADDR_W-1:0] syn_addr,
    output logic              wt_rd_en,
    output logic              wt_wr_en,
    output logic [W_W-1:0]    wt_wdata,
    output logic              busy
);

    localparam int                      AGE_W    = $clog2(WINDOW + 1);
    localparam logic [AGE_W-1:0]        C_WINDOW = AGE_W'(WINDOW);
    localparam int                      SUM_W    = W_W + 2;
    localparam logic signed [SUM_W-1:0] C_LTP    = SUM_W'(LTP_STEP);
    localparam logic signed [SUM_W-1:0] C_LTD    = SUM_W'(LTD_STEP);
    localparam logic signed [SUM_W-1:0] C_WMAX   = {2'b00, {W_W{1'b1}}};

    state_e                   r_state_q, w_state_d;
    logic [ADDR_W-1:0]        r_sel_q, w_sel_d;
    logic [ADDR_W-1:0]        r_last_q, w_last_d;
    logic [N_SYN-1:0]         r_ltp_q, w_ltp_d;
    logic [N_SYN-1:0]         r_ltd_q, w_ltd_d;
    logic                     r_cap_ltp_q, w_cap_ltp_d;
    logic                     r_cap_ltd_q, w_cap_ltd_d;
    logic [W_W-1:0]           r_wdata_q, w_wdata_d;
    logic [AGE_W-1:0]         r_pre_age_q [N_SYN];
    logic [AGE_W-1:0]         w_pre_age_d [N_SYN];
    logic [AGE_W-1:0]         r_post_age_q, w_post_age_d;

    logic [N_SYN-1:0]         w_ltp_set, w_ltd_set, w_ltp_clr, w_ltd_clr;
    logic [ADDR_W-1:0]        w_grant;
    logic                     w_grant_valid;
    logic signed [SUM_W-1:0]  w_sum;
    logic [W_W-1:0]           w_clamped;

    // Ages and pend set/clear; coincidences are decided on pre-update ages.
    always_comb begin
        w_post_age_d = r_post_age_q;
        if (en) begin
            if (post_spike)
                w_post_age_d = '0;
            else if (r_post_age_q < C_WINDOW)
                w_post_age_d = r_post_age_q + 1'b1;
        end
        for (int i = 0; i < N_SYN; i++) begin
            w_pre_age_d[i] = r_pre_age_q[i];
            if (en) begin
                if (pre_spike[i])
                    w_pre_age_d[i] = '0;
                else if (r_pre_age_q[i] < C_WINDOW)
                    w_pre_age_d[i] = r_pre_age_q[i] + 1'b1;
            end
            w_ltp_set[i] = en && post_spike && !pre_spike[i] && (r_pre_age_q[i] < C_WINDOW);
            w_ltd_set[i] = en && pre_spike[i] && !post_spike && (r_post_age_q < C_WINDOW);
            w_ltp_clr[i] = (r_state_q == ST_WRITE) && (r_sel_q == ADDR_W'(i)) && r_cap_ltp_q;
            w_ltd_clr[i] = (r_state_q == ST_WRITE) && (r_sel_q == ADDR_W'(i)) && r_cap_ltd_q;
        end
        w_ltp_d = (r_ltp_q & ~w_ltp_clr) | w_ltp_set;
        w_ltd_d = (r_ltd_q & ~w_ltd_clr) | w_ltd_set;
    end

    rr_arbiter #(
        .N_SYN  (N_SYN),
        .ADDR_W (ADDR_W)
    ) u_arb (
        .req        (r_ltp_q | r_ltd_q),
        .last_grant (r_last_q),
        .grant      (w_grant),
        .valid      (w_grant_valid)
    );

    always_comb begin
        w_sum = $signed({2'b00, wt_rdata});
        if (r_ltp_q[r_sel_q])
            w_sum = w_sum + C_LTP;
        if (r_ltd_q[r_sel_q])
            w_sum = w_sum - C_LTD;
        if (w_sum[SUM_W-1])
            w_clamped = '0;
        else if (w_sum > C_WMAX)
            w_clamped = '1;
        else
            w_clamped = w_sum[W_W-1:0];
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_sel_d     = r_sel_q;
        w_last_d    = r_last_q;
        w_cap_ltp_d = r_cap_ltp_q;
        w_cap_ltd_d = r_cap_ltd_q;
        w_wdata_d   = r_wdata_q;
        wt_rd_en    = 1'b0;
        wt_wr_en    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_sel_d   = w_grant;
                    w_state_d = ST_READ;
                end
            end
            ST_READ: begin
                wt_rd_en  = 1'b1;
                w_state_d = ST_CALC;
            end
            ST_CALC: begin
                // Only the bits seen here are retired; later arrivals survive.
                w_cap_ltp_d = r_ltp_q[r_sel_q];
                w_cap_ltd_d = r_ltd_q[r_sel_q];
                w_wdata_d   = w_clamped;
                w_state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                wt_wr_en  = 1'b1;
                w_last_d  = r_sel_q;
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_sel_q      <= '0;
            r_last_q     <= ADDR_W'(N_SYN - 1);
            r_ltp_q      <= '0;
            r_ltd_q      <= '0;
            r_cap_ltp_q  <= 1'b0;
            r_cap_ltd_q  <= 1'b0;
            r_wdata_q    <= '0;
            r_post_age_q <= C_WINDOW;
            for (int i = 0; i < N_SYN; i++)
                r_pre_age_q[i] <= C_WINDOW;
        end else begin
            r_state_q    <= w_state_d;
            r_sel_q      <= w_sel_d;
            r_last_q     <= w_last_d;
            r_ltp_q      <= w_ltp_d;
            r_ltd_q      <= w_ltd_d;
            r_cap_ltp_q  <= w_cap_ltp_d;
            r_cap_ltd_q  <= w_cap_ltd_d;
            r_wdata_q    <= w_wdata_d;
            r_post_age_q <= w_post_age_d;
            for (int i = 0; i < N_SYN; i++)
                r_pre_age_q[i] <= w_pre_age_d[i];
        end
    end

    assign syn_addr = r_sel_q;
    assign wt_wdata = r_wdata_q;
    assign busy     = (r_state_q != ST_IDLE) || (|(r_ltp_q | r_ltd_q));

endmodule
`default_nettype wire

// File: tb/tb_stdp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stdp_sched
//  Purpose  : Directed scoreboard bench for stdp_sched weight-update traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stdp_sched;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] pre_spike;
    logic       post_spike;
    logic [7:0] wt_rdata;
    logic [1:0] syn_addr;
    logic       wt_rd_en;
    logic       wt_wr_en;
    logic [7:0] wt_wdata;
    logic       busy;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   cp;

    stdp_sched dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .wt_rdata   (wt_rdata),
        .syn_addr   (syn_addr),
        .wt_rd_en   (wt_rd_en),
        .wt_wr_en   (wt_wr_en),
        .wt_wdata   (wt_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (wt_wr_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr=%0d data=%0d at cycle %0d, expected no write",
                         syn_addr, wt_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(syn_addr), 32'(e.addr));
                check("wr_data", 32'(wt_wdata), 32'(e.data));
                check("wr_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] pre, input logic post);
        pre_spike  = pre;
        post_spike = post;
        tick(1);
        pre_spike  = '0;
        post_spike = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pre_spike  = '0;
        post_spike = 1'b0;
        tick(2);
        reset      = 1'b0;
    endtask

    task automatic expect_wr(input logic [1:0] a, input logic [7:0] d, input int at);
        exp_q.push_back('{addr: a, data: d, at: at});
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_idle"}, 32'(busy), 0);
        exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        pre_spike  = '0;
        post_spike = 1'b0;
        wt_rdata   = '0;
        tick(3);
        check("rst_syn_addr", 32'(syn_addr), 0);
        check("rst_rd_en",    32'(wt_rd_en), 0);
        check("rst_wr_en",    32'(wt_wr_en), 0);
        check("rst_wdata",    32'(wt_wdata), 0);
        check("rst_busy",     32'(busy), 0);
        reset = 1'b0;

        // pre then post 3 cycles later: LTP on synapse 0, en dropped mid-flight
        do_reset();
        wt_rdata = 8'd10;
        pulse(4'b0001, 1'b0);
        tick(2);
        cp = cyc;
        expect_wr(2'd0, 8'd11, cp + 4);
        pulse(4'b0000, 1'b1);
        en = 1'b0;
        drain("ltp_basic", 30);
        en = 1'b1;

        // post then pre[2]: LTD from weight 0 clamps at 0
        do_reset();
        wt_rdata = 8'd0;
        pulse(4'b0000, 1'b1);
        tick(1);
        cp = cyc;
        expect_wr(2'd2, 8'd0, cp + 4);
        pulse(4'b0100, 1'b0);
        drain("ltd_clamp", 30);

        // all four synapses potentiated, serviced 0..3 four cycles apart
        do_reset();
        wt_rdata = 8'd5;
        pulse(4'b1111, 1'b0);
        cp = cyc;
        for (int k = 0; k < 4; k++)
            expect_wr(2'(k), 8'd6, cp + 4 + 4 * k);
        pulse(4'b0000, 1'b1);
        drain("rr_order", 60);

        // saturation at 255, then window edge: 9 cycles misses, 8 cycles hits
        do_reset();
        wt_rdata = 8'd255;
        pulse(4'b1000, 1'b0);
        cp = cyc;
        expect_wr(2'd3, 8'd255, cp + 4);
        pulse(4'b0000, 1'b1);
        drain("sat_hi", 30);
        tick(12);
        pulse(4'b0010, 1'b0);
        tick(8);
        pulse(4'b0000, 1'b1);
        tick(15);
        drain("window_miss", 30);
        pulse(4'b0010, 1'b0);
        tick(7);
        cp = cyc;
        expect_wr(2'd1, 8'd255, cp + 4);
        pulse(4'b0000, 1'b1);
        drain("window_hit", 30);

        // LTP re-trigger in synapse 1's WRITE cycle is serviced right after
        do_reset();
        wt_rdata = 8'd20;
        pulse(4'b0010, 1'b0);
        cp = cyc;
        expect_wr(2'd1, 8'd21, cp + 4);
        expect_wr(2'd1, 8'd21, cp + 8);
        pulse(4'b0000, 1'b1);
        tick(3);
        pulse(4'b0000, 1'b1);
        drain("retrigger", 40);

        // simultaneous pre/post produces neither LTP nor LTD
        do_reset();
        wt_rdata = 8'd50;
        pulse(4'b0001, 1'b0);
        tick(1);
        pulse(4'b0001, 1'b1);
        tick(15);
        drain("coinc_ltp", 30);
        pulse(4'b0000, 1'b1);
        tick(1);
        pulse(4'b0001, 1'b1);
        tick(15);
        drain("coinc_ltd", 30);

        // reset during CALC aborts the update with no write strobe
        do_reset();
        wt_rdata = 8'd10;
        pulse(4'b0001, 1'b0);
        cp = cyc;
        pulse(4'b0000, 1'b1);
        tick(1);
        check("abort_read_strobe", 32'(wt_rd_en), 1);
        check("abort_read_addr",   32'(syn_addr), 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_write", 32'(wt_wr_en), 0);
        check("abort_not_busy", 32'(busy), 0);
        tick(10);
        drain("abort", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1);
    end

endmodule
`default_nettype wire
